// File: rtl/mips_pkg.sv
// Shared datapath constants and ALU B-operand select encodings for the ID/EX boundary.
package mips_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_IMM_W  = 16;
  localparam int DEF_REG_AW = 5;

  typedef enum logic [1:0] {
    SRC_REG   = 2'b00,
    SRC_SEXT  = 2'b01,
    SRC_ZEXT  = 2'b10,
    SRC_UPPER = 2'b11
  } alu_src_e;

endpackage

// File: rtl/fwd_select.sv
// Per-source bypass select: EX/MEM beats MEM/WB, register 0 is never bypassed.
module fwd_select #(
  parameter int WIDTH  = mips_pkg::DEF_WIDTH,
  parameter int REG_AW = mips_pkg::DEF_REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic [WIDTH-1:0]  rf_data,
  input  logic              exmem_we,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [WIDTH-1:0]  exmem_result,
  input  logic              memwb_we,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [WIDTH-1:0]  memwb_result,
  output logic [WIDTH-1:0]  value,
  output logic              hit
);

  logic src_nz;
  logic exmem_hit;
  logic memwb_hit;

  assign src_nz    = (src != '0);
  assign exmem_hit = exmem_we && (exmem_rd == src) && src_nz;
  assign memwb_hit = memwb_we && (memwb_rd == src) && src_nz;

  always_comb begin
    value = rf_data;
    hit   = 1'b0;
    if (exmem_hit) begin
      value = exmem_result;
      hit   = 1'b1;
    end else if (memwb_hit) begin
      value = memwb_result;
      hit   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwarded A/B/store-data selection with immediate modes,
// a registered output with stall/flush/valid, and a saturating forwarding counter.
module alu_operand_stage
  import mips_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [1:0]        ALUSrc,
  input  logic [REG_AW-1:0] Rs,
  input  logic [REG_AW-1:0] Rt,
  input  logic [WIDTH-1:0]  ReadData1,
  input  logic [WIDTH-1:0]  ReadData2,
  input  logic [IMM_W-1:0]  Imm,
  input  logic              ExMemRegWrite,
  input  logic [REG_AW-1:0] ExMemRd,
  input  logic [WIDTH-1:0]  ExMemResult,
  input  logic              MemWbRegWrite,
  input  logic [REG_AW-1:0] MemWbRd,
  input  logic [WIDTH-1:0]  MemWbResult,
  output logic [WIDTH-1:0]  ALU_A,
  output logic [WIDTH-1:0]  ALU_B,
  output logic [WIDTH-1:0]  StoreData,
  output logic              OutValid,
  output logic [CNT_W-1:0]  FwdCount
);

  function automatic logic [WIDTH-1:0] imm_ext(input logic [1:0] sel, input logic [IMM_W-1:0] imm);
    logic signed [IMM_W-1:0] imm_s;
    logic [WIDTH-1:0]        zext;
    imm_s = imm;
    zext  = {{(WIDTH-IMM_W){1'b0}}, imm};
    case (alu_src_e'(sel))
      SRC_SEXT:  return {{(WIDTH-IMM_W){imm_s[IMM_W-1]}}, imm_s};
      SRC_UPPER: return zext << IMM_W;
      default:   return zext;
    endcase
  endfunction

  // Counter never wraps: a carry out of the top bit pins it at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    if (sum[CNT_W]) return '1;
    return sum[CNT_W-1:0];
  endfunction

  // Stage p0: operand selection (combinational)
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] rt_p0;
  logic [WIDTH-1:0] b_p0;
  logic             hit_a_p0;
  logic             hit_rt_p0;
  logic [1:0]       inc_p0;
  logic             accept_p0;

  fwd_select #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_rs (
    .src          (Rs),
    .rf_data      (ReadData1),
    .exmem_we     (ExMemRegWrite),
    .exmem_rd     (ExMemRd),
    .exmem_result (ExMemResult),
    .memwb_we     (MemWbRegWrite),
    .memwb_rd     (MemWbRd),
    .memwb_result (MemWbResult),
    .value        (a_p0),
    .hit          (hit_a_p0)
  );

  fwd_select #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_rt (
    .src          (Rt),
    .rf_data      (ReadData2),
    .exmem_we     (ExMemRegWrite),
    .exmem_rd     (ExMemRd),
    .exmem_result (ExMemResult),
    .memwb_we     (MemWbRegWrite),
    .memwb_rd     (MemWbRd),
    .memwb_result (MemWbResult),
    .value        (rt_p0),
    .hit          (hit_rt_p0)
  );

  assign b_p0      = (alu_src_e'(ALUSrc) == SRC_REG) ? rt_p0 : imm_ext(ALUSrc, Imm);
  assign inc_p0    = {1'b0, hit_a_p0} + {1'b0, hit_rt_p0};
  assign accept_p0 = InValid && !Stall && !Flush;

  // Stage p1: registered operands, valid and counter
  logic [WIDTH-1:0] alu_a_p1;
  logic [WIDTH-1:0] alu_b_p1;
  logic [WIDTH-1:0] store_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      alu_a_p1 <= '0;
      alu_b_p1 <= '0;
      store_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (Flush || !Stall) begin
      alu_a_p1 <= a_p0;
      alu_b_p1 <= b_p0;
      store_p1 <= rt_p0;
      vld_p1   <= InValid && !Flush;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_p1 <= '0;
    end else if (accept_p0) begin
      cnt_p1 <= sat_add(cnt_p1, inc_p0);
    end
  end

  assign ALU_A     = alu_a_p1;
  assign ALU_B     = alu_b_p1;
  assign StoreData = store_p1;
  assign OutValid  = vld_p1;
  assign FwdCount  = cnt_p1;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Parametrised successor to the single-bit ALUSrc B-operand mux.
- Sits between ID and EX. Selects both ALU operands (A and B) plus store data.
- Adds EX/MEM and MEM/WB forwarding, four immediate modes on B, and a registered output stage with stall, flush and valid.
- Also keeps a saturating forwarding-event counter for performance monitoring.

Parameters:
- WIDTH, 32, datapath width in bits; must be greater than IMM_W.
- IMM_W, 16, immediate field width.
- REG_AW, 5, register-number width.
- CNT_W, 16, width of the forwarding-event counter.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- InValid  in  1  ID stage holds a valid instruction
- Stall  in  1  hold output stage
- Flush  in  1  squash the instruction being captured
- ALUSrc  in  2  B select: 00 register, 01 sign-ext imm, 10 zero-ext imm, 11 upper imm
- Rs  in  REG_AW  source register A number
- Rt  in  REG_AW  source register B number
- ReadData1  in  WIDTH  register file port 1
- ReadData2  in  WIDTH  register file port 2
- Imm  in  IMM_W  immediate field
- ExMemRegWrite  in  1  EX/MEM will write a register
- ExMemRd  in  REG_AW  EX/MEM destination register
- ExMemResult  in  WIDTH  EX/MEM result
- MemWbRegWrite  in  1  MEM/WB will write a register
- MemWbRd  in  REG_AW  MEM/WB destination register
- MemWbResult  in  WIDTH  MEM/WB result
- ALU_A  out  WIDTH  registered operand A
- ALU_B  out  WIDTH  registered operand B
- StoreData  out  WIDTH  registered forwarded Rt value
- OutValid  out  1  registered outputs are valid
- FwdCount  out  CNT_W  saturating count of forwarding events

Behaviour:
- Reset: ALU_A, ALU_B, StoreData, OutValid and FwdCount all go to 0. Reset has priority over Flush and Stall.
- Latency: 1 cycle. Inputs are sampled at edge N and appear on the outputs after edge N.
- Forwarding, evaluated per source (Rs, Rt):
  - If ExMemRegWrite, ExMemRd == src and src != 0, use ExMemResult.
  - Otherwise, if MemWbRegWrite, MemWbRd == src and src != 0, use MemWbResult.
  - Otherwise use the register file data.
  - EX/MEM always has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand A = forwarded Rs value.
- StoreData = forwarded Rt value, regardless of ALUSrc.
- Operand B by ALUSrc:
  - 00: forwarded Rt value.
  - 01: Imm sign-extended to WIDTH.
  - 10: Imm zero-extended to WIDTH.
  - 11: Imm shifted left by IMM_W, truncated to WIDTH, zero-filled low bits.
- Output register update:
  - Flush (and not Reset): OutValid goes to 0; data registers are loaded normally (don't-care). Flush has priority over Stall.
  - Stall (and not Flush): all outputs, including OutValid, hold.
  - Otherwise: load the new operands; OutValid = InValid.
- Accepted cycle = InValid & !Stall & !Flush & !Reset. Only accepted cycles affect FwdCount.
- FwdCount increments by fwdA + fwdRt (0, 1 or 2):
  - fwdA = 1 when Rs was forwarded.
  - fwdRt = 1 when Rt was forwarded and (ALUSrc == 00, or the instruction is a store: not distinguishable here, so count Rt forwarding whenever it occurs).
  - The sum saturates at 2^CNT_W - 1. It never wraps.
- Simultaneous hit of the same register in EX/MEM and MEM/WB: EX/MEM wins.
- Reset asserted mid-stall clears everything; after deassertion OutValid stays 0 until the next accepted cycle.

Decomposition:
- Shared package mips_pkg holds:
  - ALUSrc encodings: SRC_REG, SRC_SEXT, SRC_ZEXT, SRC_UPPER.
  - Default WIDTH, IMM_W and REG_AW constants.
- One sub-module, fwd_select: compares one source against EX/MEM and MEM/WB and returns the selected value plus a hit flag. It is instantiated twice (Rs, Rt).

Test Plan:
- Reset: hold Reset for 2 cycles, then drop it -> all outputs 0; FwdCount = 0.
- Immediate modes: ALUSrc = 01, Imm = 16'hFFFE -> ALU_B = 32'hFFFFFFFE. ALUSrc = 10 -> 32'h0000FFFE. ALUSrc = 11, Imm = 16'h1234 -> 32'h12340000. Each appears 1 cycle later with OutValid = 1.
- Forwarding priority: Rs = 3, ExMemRd = 3 (result 32'hAAAA0000), MemWbRd = 3 (result 32'h5555) -> ALU_A = 32'hAAAA0000, FwdCount += 1. Repeat with Rs = 0 and ExMemRd = 0 -> ALU_A = ReadData1, no count.
- Store path: ALUSrc = 01, Rt = 7 forwarded from MemWb with value 9 -> StoreData = 9, ALU_B = immediate, FwdCount += 1.
- Stall/flush: load a value, assert Stall for 3 cycles while changing inputs -> outputs frozen. Assert Stall and Flush together -> OutValid = 0 next cycle and FwdCount unchanged.
- Saturation: CNT_W = 2, drive double-forward accepted cycles (Rs and Rt both forwarded) -> count sequence 0, 2, 3, 3.
